// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } fetch_state_e;

    function automatic logic isAligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Single-entry output register holding one fetched instruction and its address for decode.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic            ready_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o
);

    logic            valid_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;

    // Payload only changes on load, so it stays stable while decode stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: one outstanding memory request, redirect handling with
// response kill, and a sticky fault on misaligned redirect targets.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        misalign_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         kill_q, kill_d;
    logic         fault_q, fault_d;
    logic         req_q;
    logic         bufLoad;
    logic         bufFlush;

    // Redirect outranks every other event; FAULT is absorbing until reset.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        kill_d   = kill_q;
        fault_d  = fault_q;
        bufLoad  = 1'b0;
        bufFlush = 1'b0;

        if (state_q != FAULT && redirect_valid) begin
            bufFlush = 1'b1;
            if (!isAligned(redirect_target)) begin
                fault_d = 1'b1;
                kill_d  = 1'b0;
                state_d = FAULT;
            end else begin
                pc_d = redirect_target;
                unique case (state_q)
                    WAIT: begin
                        kill_d  = !imem_rvalid;
                        state_d = imem_rvalid ? REQ : WAIT;
                    end
                    REQ: begin
                        kill_d  = imem_gnt;
                        state_d = imem_gnt ? WAIT : REQ;
                    end
                    default: state_d = REQ;
                endcase
            end
        end else begin
            unique case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem_gnt) state_d = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = REQ;
                        end else begin
                            bufLoad = 1'b1;
                            pc_d    = pc_q + INSTR_BYTES;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) state_d = REQ;
                end
                FAULT:   state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            fault_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            fault_q <= fault_d;
            req_q   <= (state_d == REQ);
        end
    end

    fetch_buf u_fetch_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (bufLoad),
        .flush_i (bufFlush),
        .ready_i (instr_ready),
        .instr_i (imem_rdata),
        .pc_i    (pc_q),
        .valid_o (instr_valid),
        .instr_o (instr),
        .pc_o    (instr_pc)
    );

    assign imem_req       = req_q;
    assign imem_addr      = pc_q;
    assign misalign_fault = fault_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 redirect_valid  in  1  branch_taken from branch_unit OR jump; target applies this cycle.
REQ-005 redirect_target  in  32  new PC for redirect.
REQ-006 imem_req  out  1  instruction-memory request.
REQ-007 imem_addr  out  32  request address = current pc.
REQ-008 imem_gnt  in  1  memory accepted request this cycle.
REQ-009 imem_rvalid  in  1  response data valid, exactly one per granted request, >=1 cycle after gnt.
REQ-010 imem_rdata  in  32  response instruction word.
REQ-011 instr_valid  out  1  fetched instruction available to decode.
REQ-012 instr  out  32  instruction word.
REQ-013 instr_pc  out  32  address of instr.
REQ-014 instr_ready  in  1  decode accepts instr when instr_valid && instr_ready.
REQ-015 misalign_fault  out  1  sticky: redirect_target[1:0] != 2'b00 received.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, HOLD, FAULT.
REQ-017 IDLE: one cycle after reset deassertion, unconditionally -> REQ.
REQ-018 REQ: imem_req=1, imem_addr=pc; on imem_gnt -> WAIT.
REQ-019 WAIT: imem_req=0; on imem_rvalid with kill=0: buffer <= {imem_rdata, pc}, pc <= pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), -> HOLD.
REQ-020 HOLD: instr_valid=1; on instr_ready -> REQ next cycle (min 3 cycles/instruction).
REQ-021 instr and instr_pc SHALL stay stable while instr_valid && !instr_ready.
REQ-022 Redirect (aligned) SHALL have priority over every other event: pc <= redirect_target; buffer flushed (instr_valid=0 next cycle).
REQ-023 Redirect in IDLE, HOLD, or REQ without imem_gnt: -> REQ; imem_addr = target the following cycle (memory samples addr only on gnt).
REQ-024 Redirect in WAIT, or in REQ with imem_gnt same cycle: set kill, -> WAIT; response arriving with kill=1 SHALL be discarded, kill cleared, -> REQ.
REQ-025 Redirect on the same cycle as the killed response's imem_rvalid: response discarded, pc <= newest target, -> REQ.
REQ-026 Redirect same cycle as instr_valid && instr_ready: handshake completes (decode consumed it); redirect still applied.
REQ-027 Misaligned redirect: misalign_fault <= 1, -> FAULT, pc unchanged; FAULT issues no requests, instr_valid=0, ignores all inputs until reset; outstanding response dropped.
REQ-028 At most one request outstanding at any time.

Reset
REQ-029 While rst_n=0 at clk edge: state=IDLE, pc=RESET_PC, kill=0, buffer empty.
REQ-030 Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, misalign_fault=0.
REQ-031 Reset mid-WAIT SHALL abandon the outstanding request; memory must also be reset (a late rvalid after reset is not supported).

Structure
REQ-032 Package fetch_pkg SHALL hold the state enum, INSTR_BYTES=4, and RESET_PC default.
REQ-033 One sub-module, fetch_buf: single-entry output register {instr, instr_pc} with load, flush, valid/ready; FSM and pc stay in fetch_unit.

Verification
REQ-034 Reset, gnt same cycle as req, rvalid 1 cycle later, ready=1 -> instr_pc sequence 0x0, 0x4, 0x8 with matching imem_rdata.
REQ-035 instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc unchanged, imem_req=0 throughout; ready=1 -> imem_req at addr 0x4 next cycle.
REQ-036 Redirect to 0x100 in WAIT (rvalid 3 cycles later, rdata 0xDEAD_BEEF) -> word never appears on instr; next imem_addr=0x100, instr_pc=0x100.
REQ-037 Redirect to 0x202 -> misalign_fault=1 next cycle, imem_req=0 permanently, instr_valid=0 until rst_n=0.
REQ-038 Redirect to 0xFFFF_FFFC, fetch two words -> instr_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-039 rst_n=0 asserted in WAIT -> next cycle all outputs at reset values; fetch restarts at RESET_PC.
